// File: rtl/cache_backing_mem_pkg.sv
// Shared types and widths for the cache backing memory.
package cache_backing_mem_pkg;

  localparam int BLOCK_WIDTH = 128;
  localparam int ADDR_WIDTH  = 28;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/cache_backing_mem_array.sv
// backing_mem_array: single-port block storage, synchronous write,
// asynchronous read. Contents are not reset.
module backing_mem_array #(
  parameter int ADDR_BITS = 8,
  parameter int WIDTH     = 128
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

  // Commit a block on the write strobe
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/cache_backing_mem.sv
// cache_backing_mem: fixed-latency block memory behind a cache.
// A request is seen combinationally in IDLE (busywait rises at once),
// latched on the next edge, then held in BUSY for LATENCY cycles.
// Optional build macro CACHE_BACKING_MEM_STATS_EN adds the rd_count /
// wr_count completed-access counters.
module cache_backing_mem
  import cache_backing_mem_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [BLOCK_WIDTH-1:0] mem_writedata,
  output logic [BLOCK_WIDTH-1:0] mem_readdata,
  output logic                   mem_busywait,
  output logic                   mem_err
`ifdef CACHE_BACKING_MEM_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                 r_state, w_next;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic                   r_op_wr;

  logic                   w_start, w_commit, w_conflict, w_we;
  logic [BLOCK_WIDTH-1:0] w_rdata;

  // Upper address bits are deliberately not decoded (index wraps)
  logic w_addr_unused;
  assign w_addr_unused = ^mem_address[ADDR_WIDTH-1:ADDR_BITS];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: exactly one request starts an access, counter expiry ends it
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (mem_read ^ mem_write) w_next = BUSY;
      BUSY: if (r_cnt == 4'd0)        w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs/strobes: busywait covers the request cycle plus all BUSY cycles
  always_comb begin
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_conflict   = 1'b0;
    mem_busywait = 1'b0;
    case (r_state)
      IDLE: begin
        w_start      = mem_read ^ mem_write;
        w_conflict   = mem_read & mem_write;
        mem_busywait = mem_read ^ mem_write;
      end
      BUSY: begin
        w_commit     = (r_cnt == 4'd0);
        mem_busywait = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch request, count down, capture read block, sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op_wr      <= 1'b0;
      mem_readdata <= '0;
      mem_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= mem_address[ADDR_BITS-1:0];
        r_wdata <= mem_writedata;
        r_op_wr <= mem_write;
        r_cnt   <= CNT_INIT;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_op_wr) mem_readdata <= w_rdata;
      if (w_conflict)           mem_err      <= 1'b1;
    end
  end

  // Array has no reset, so a reset on the commit edge must suppress the write
  assign w_we = w_commit & r_op_wr & reset;

  backing_mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (BLOCK_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

`ifdef CACHE_BACKING_MEM_STATS_EN
  // Saturating completed-access counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (w_commit) begin
      if (!r_op_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if ( r_op_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/cache_backing_mem.md
CACHE_BACKING_MEM -- requirements
Module: cache_backing_mem

Interface
REQ-001 Parameter LATENCY, default 5, SHALL set the busy cycles per access (legal range 1..15).
REQ-002 Parameter ADDR_BITS, default 8, SHALL set the block-index width (2^ADDR_BITS blocks of 128 bits).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low.
REQ-005 mem_read  input  1  block read request from the cache, held until busywait falls.
REQ-006 mem_write  input  1  block write request from the cache, held until busywait falls.
REQ-007 mem_address  input  28  block address; only bits [ADDR_BITS-1:0] SHALL be decoded, upper bits ignored.
REQ-008 mem_writedata  input  128  write block, word 0 in bits [31:0].
REQ-009 mem_readdata  output  128  read block, valid from the cycle busywait falls until the next accepted read.
REQ-010 mem_busywait  output  1  stall to the cache while an access is in progress.
REQ-011 mem_err  output  1  sticky flag for an illegal request.

Function
REQ-012 FSM SHALL have states IDLE and BUSY.
REQ-013 In IDLE with exactly one of mem_read/mem_write high, mem_busywait SHALL be 1 combinationally in that same cycle, and the next edge SHALL latch address, data and op, load the counter with LATENCY-1, and enter BUSY.
REQ-014 In BUSY, mem_busywait SHALL be 1 and the counter SHALL decrement each edge.
REQ-015 The edge at counter==0 SHALL commit the write to the array, or load mem_readdata from the array, and return to IDLE; mem_busywait SHALL be 0 in the following cycle.
REQ-016 Total busy span SHALL be exactly LATENCY+1 cycles, counting from the cycle the request is first seen.
REQ-017 Address and data SHALL be taken from the latched copy only; input changes during BUSY SHALL have no effect.
REQ-018 mem_read and mem_write both high in IDLE SHALL be ignored: no busywait, no array access, and mem_err set to 1.
REQ-019 A request still high in the first IDLE cycle after completion SHALL start a new access, with back-to-back accesses allowed.
REQ-020 Block-index arithmetic SHALL wrap modulo 2^ADDR_BITS: index 0xFF and 0x1FF SHALL alias when ADDR_BITS=8.
REQ-021 A read following a write to the same index SHALL return the newly written block.

Reset
REQ-022 reset low at a clock edge SHALL force IDLE, counter=0, mem_readdata=0, mem_err=0, and mem_busywait=0 in the next cycle.
REQ-023 Reset during BUSY SHALL abort the access without committing the write.
REQ-024 Array contents SHALL NOT be cleared by reset; simulation initial contents are 0.

Configuration
REQ-025 With macro CACHE_BACKING_MEM_STATS_EN defined, the block SHALL add 16-bit outputs rd_count and wr_count.
REQ-026 rd_count and wr_count SHALL increment once per completed read or write, saturate at 0xFFFF, and clear on reset.
REQ-027 Without the macro, these ports and their counters SHALL NOT exist.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=1'b0, BUSY=1'b1), BLOCK_WIDTH=128 and ADDR_WIDTH=28.
REQ-029 The storage array SHALL be a single sub-module, backing_mem_array: 1 read/write port, synchronous write, and array read sampled into mem_readdata on the commit edge.

Verification
REQ-030 Write 0x11112222_33334444_55556666_77778888 to index 0x05, then read index 0x05 -> busywait high for 6 cycles each, and readdata equals the written block.
REQ-031 Read asserted with mem_address changed to 0x09 in the second busy cycle -> data returned from the originally latched index 0x05.
REQ-032 mem_read=mem_write=1 in IDLE -> busywait stays 0, mem_err=1 and stays set until reset.
REQ-033 Write to 0x07 with reset asserted in the third busy cycle -> next cycle IDLE and busywait=0; a later read of 0x07 returns the prior contents.
REQ-034 Read of 0x0FF after a write to 0x1FF with ADDR_BITS=8 -> the written block is returned (alias).
REQ-035 With CACHE_BACKING_MEM_STATS_EN, 3 reads and 2 writes -> rd_count=3, wr_count=2; after reset both are 0.
